// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen register interface and the bus-side initiator.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StResponse
    } rggen_initiator_state;

    // Bit width needed to hold values 0..n-1, never less than one bit.
    function automatic int unsigned rggen_clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rggen_response_collector.sv
// Combines one-hot register responses into a single selected response.
module rggen_response_collector
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned REGISTERS = 1,
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic [REGISTERS-1:0]           i_active,
    input  logic [REGISTERS-1:0]           i_ready,
    input  logic [2*REGISTERS-1:0]         i_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_read_data,
    output logic                           o_any_active,
    output logic                           o_multi_active,
    output logic                           o_selected_ready,
    output rggen_status                    o_selected_status,
    output logic [BUS_WIDTH-1:0]           o_selected_read_data
);

    logic [1:0] status_or;

    // AND-OR mux; only meaningful when exactly one active bit is set.
    always_comb begin
        o_any_active         = |i_active;
        // Clearing the lowest set bit leaves something only if two or more were set.
        o_multi_active       = |(i_active & (i_active - REGISTERS'(1)));
        o_selected_ready     = 1'b0;
        status_or            = '0;
        o_selected_read_data = '0;
        for (int i = 0; i < int'(REGISTERS); i++) begin
            o_selected_ready     |= i_active[i] & i_ready[i];
            status_or            |= {2{i_active[i]}} & i_status[2*i+:2];
            o_selected_read_data |= {BUS_WIDTH{i_active[i]}} & i_read_data[BUS_WIDTH*i+:BUS_WIDTH];
        end
        o_selected_status = rggen_status'(status_or);
    end

endmodule

// File: rtl/rggen_register_initiator.sv
// Single-outstanding initiator: host valid/ready request in, shared register
// request out, one registered response back to the host.
module rggen_register_initiator
    import rggen_rtl_pkg::*;
#(
    parameter int unsigned          ADDRESS_WIDTH     = 8,
    parameter int unsigned          BUS_WIDTH         = 32,
    parameter int unsigned          REGISTERS         = 1,
    parameter int unsigned          TIMEOUT_CYCLES    = 0,
    parameter bit                   ERROR_STATUS      = 1'b1,
    parameter logic [BUS_WIDTH-1:0] DEFAULT_READ_DATA = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_request_valid,
    output logic                           o_request_ready,
    input  logic                           i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]       i_request_address,
    input  logic [BUS_WIDTH-1:0]           i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_request_strobe,
    output logic                           o_response_valid,
    input  logic                           i_response_ready,
    output rggen_status                    o_response_status,
    output logic [BUS_WIDTH-1:0]           o_response_read_data,
    output logic                           o_register_valid,
    output rggen_access                    o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int unsigned STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int unsigned COUNT_WIDTH  = rggen_clog2_min1(TIMEOUT_CYCLES + 1);
    localparam logic [COUNT_WIDTH-1:0]   COUNT_MAX    = '1;
    localparam logic [COUNT_WIDTH-1:0]   COUNT_LIMIT  = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK = ~ADDRESS_WIDTH'(STROBE_WIDTH - 1);

    rggen_initiator_state state_q, state_d;

    rggen_access                access_q;
    logic [ADDRESS_WIDTH-1:0]   address_q;
    logic [BUS_WIDTH-1:0]       write_data_q;
    logic [STROBE_WIDTH-1:0]    strobe_q;
    logic [COUNT_WIDTH-1:0]     count_q, count_d;
    rggen_status                status_q;
    logic [BUS_WIDTH-1:0]       read_data_q;

    logic                       any_active;
    logic                       multi_active;
    logic                       selected_ready;
    rggen_status                selected_status;
    logic [BUS_WIDTH-1:0]       selected_read_data;

    logic                       access_done;
    rggen_status                access_status;
    logic [BUS_WIDTH-1:0]       access_read_data;
    logic                       is_read;

    rggen_response_collector #(
        .REGISTERS (REGISTERS),
        .BUS_WIDTH (BUS_WIDTH)
    ) u_collector (
        .i_active             (i_register_active),
        .i_ready              (i_register_ready),
        .i_status             (i_register_status),
        .i_read_data          (i_register_read_data),
        .o_any_active         (any_active),
        .o_multi_active       (multi_active),
        .o_selected_ready     (selected_ready),
        .o_selected_status    (selected_status),
        .o_selected_read_data (selected_read_data)
    );

    assign is_read = (access_q == RGGEN_READ);

    // Prioritised evaluation of the register responses during an access.
    always_comb begin
        access_done      = 1'b0;
        access_status    = RGGEN_OKAY;
        access_read_data = '0;
        count_d          = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_WIDTH'(1);
        if (!any_active) begin
            access_done      = 1'b1;
            access_status    = ERROR_STATUS ? RGGEN_DECODE_ERROR : RGGEN_OKAY;
            access_read_data = is_read ? DEFAULT_READ_DATA : '0;
        end else if (multi_active) begin
            access_done   = 1'b1;
            access_status = RGGEN_SLAVE_ERROR;
        end else if (selected_ready) begin
            access_done      = 1'b1;
            access_status    = selected_status;
            access_read_data = is_read ? selected_read_data : '0;
        end else if ((TIMEOUT_CYCLES != 0) && (count_d == COUNT_LIMIT)) begin
            access_done   = 1'b1;
            access_status = RGGEN_SLAVE_ERROR;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (i_request_valid)  state_d = StAccess;
            StAccess:   if (access_done)      state_d = StResponse;
            StResponse: if (i_response_ready) state_d = StIdle;
            default:                          state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the current state.
    always_comb begin
        o_request_ready  = (state_q == StIdle);
        o_register_valid = (state_q == StAccess);
        o_response_valid = (state_q == StResponse);
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            access_q     <= rggen_access'(2'b00);
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            count_q      <= '0;
            status_q     <= RGGEN_OKAY;
            read_data_q  <= '0;
        end else begin
            if ((state_q == StIdle) && i_request_valid) begin
                access_q     <= i_request_write ? RGGEN_WRITE : RGGEN_READ;
                address_q    <= i_request_address & ADDRESS_MASK;
                write_data_q <= i_request_write ? i_request_write_data : '0;
                strobe_q     <= i_request_write ? i_request_strobe : '1;
                count_q      <= '0;
            end
            if (state_q == StAccess) begin
                count_q <= count_d;
                if (access_done) begin
                    status_q    <= access_status;
                    read_data_q <= access_read_data;
                end
            end
        end
    end

    assign o_register_access     = access_q;
    assign o_register_address    = address_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;
    assign o_response_status     = status_q;
    assign o_response_read_data  = read_data_q;

endmodule

// File: tb/tb_rggen_register_initiator.sv
// Directed bench for rggen_register_initiator with two responders.
module tb_rggen_register_initiator;
    import rggen_rtl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_valid_b, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic        rsp_ready;
    logic [1:0]  reg_active, reg_ready;
    logic [3:0]  reg_status;
    logic [63:0] reg_rdata;

    logic        req_ready, rsp_valid, reg_valid;
    rggen_status rsp_status;
    logic [31:0] rsp_rdata, reg_wdata;
    rggen_access reg_access;
    logic [7:0]  reg_addr;
    logic [3:0]  reg_strb;

    logic        b_req_ready, b_rsp_valid, b_reg_valid;
    rggen_status b_rsp_status;
    logic [31:0] b_rsp_rdata, b_reg_wdata;
    rggen_access b_reg_access;
    logic [7:0]  b_reg_addr;
    logic [3:0]  b_reg_strb;

    int n_cmp = 0;
    int n_err = 0;

    rggen_register_initiator #(
        .ADDRESS_WIDTH     (8),
        .BUS_WIDTH         (32),
        .REGISTERS         (2),
        .TIMEOUT_CYCLES    (4),
        .ERROR_STATUS      (1'b1),
        .DEFAULT_READ_DATA (32'hCAFE0000)
    ) dut (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_request_valid       (req_valid),
        .o_request_ready       (req_ready),
        .i_request_write       (req_write),
        .i_request_address     (req_addr),
        .i_request_write_data  (req_wdata),
        .i_request_strobe      (req_strb),
        .o_response_valid      (rsp_valid),
        .i_response_ready      (rsp_ready),
        .o_response_status     (rsp_status),
        .o_response_read_data  (rsp_rdata),
        .o_register_valid      (reg_valid),
        .o_register_access     (reg_access),
        .o_register_address    (reg_addr),
        .o_register_write_data (reg_wdata),
        .o_register_strobe     (reg_strb),
        .i_register_active     (reg_active),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_rdata)
    );

    // Second instance: unmapped accesses return OKAY, no timeout.
    rggen_register_initiator #(
        .ADDRESS_WIDTH     (8),
        .BUS_WIDTH         (32),
        .REGISTERS         (2),
        .TIMEOUT_CYCLES    (0),
        .ERROR_STATUS      (1'b0),
        .DEFAULT_READ_DATA (32'hCAFE0000)
    ) dut_ok (
        .i_clk                 (clk),
        .i_rst                 (rst),
        .i_request_valid       (req_valid_b),
        .o_request_ready       (b_req_ready),
        .i_request_write       (req_write),
        .i_request_address     (req_addr),
        .i_request_write_data  (req_wdata),
        .i_request_strobe      (req_strb),
        .o_response_valid      (b_rsp_valid),
        .i_response_ready      (rsp_ready),
        .o_response_status     (b_rsp_status),
        .o_response_read_data  (b_rsp_rdata),
        .o_register_valid      (b_reg_valid),
        .o_register_access     (b_reg_access),
        .o_register_address    (b_reg_addr),
        .o_register_write_data (b_reg_wdata),
        .o_register_strobe     (b_reg_strb),
        .i_register_active     (reg_active),
        .i_register_ready      (reg_ready),
        .i_register_status     (reg_status),
        .i_register_read_data  (reg_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single edge; returns #1 after the accepting edge.
    task automatic issue(input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_strb  = s;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || reg_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valids: got rsp %b reg %b want 0 0", rsp_valid, reg_valid);
        end
        n_cmp++;
        if (reg_addr !== 8'h00 || reg_wdata !== 32'h0 || reg_strb !== 4'h0) begin
            n_err++;
            $display("FAIL reset_request_outs: got %h %h %h want 00 0 0", reg_addr, reg_wdata, reg_strb);
        end
        n_cmp++;
        if (reg_access !== 2'b00) begin
            n_err++; $display("FAIL reset_access: got %b want 00", reg_access);
        end
        n_cmp++;
        if (rsp_status !== 2'b00 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL reset_response: got %0d %h want 0 0", rsp_status, rsp_rdata);
        end
    endtask

    task automatic test_read();
        reg_active = 2'b10;
        reg_ready  = 2'b10;
        reg_status = 4'b0010;  // reg1 OKAY, reg0 SLAVE_ERROR (must not leak)
        reg_rdata  = {32'hDEADBEEF, 32'h11111111};
        rsp_ready  = 1'b1;
        issue(1'b0, 8'h04, 32'hFFFFFFFF, 4'h3);
        n_cmp++;
        if (reg_valid !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL read_access_phase: got regv %b reqr %b rspv %b want 1 0 0",
                     reg_valid, req_ready, rsp_valid);
        end
        n_cmp++;
        if (reg_access !== RGGEN_READ || reg_addr !== 8'h04) begin
            n_err++; $display("FAIL read_request: got %b %h want 10 04", reg_access, reg_addr);
        end
        n_cmp++;
        if (reg_wdata !== 32'h0 || reg_strb !== 4'hF) begin
            n_err++; $display("FAIL read_wdata_strb: got %h %h want 0 f", reg_wdata, reg_strb);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || reg_valid !== 1'b0) begin
            n_err++; $display("FAIL read_rsp_valid: got %b %b want 1 0", rsp_valid, reg_valid);
        end
        n_cmp++;
        if (rsp_status !== RGGEN_OKAY || rsp_rdata !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL read_rsp_data: got %0d %h want 0 deadbeef", rsp_status, rsp_rdata);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL read_back_idle: got %b %b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_write();
        reg_active = 2'b01;
        reg_ready  = 2'b01;
        reg_status = 4'b0000;
        reg_rdata  = {32'h0, 32'hFFFFFFFF};
        issue(1'b1, 8'h0B, 32'h12345678, 4'b0101);
        n_cmp++;
        if (reg_access !== RGGEN_WRITE || reg_addr !== 8'h08) begin
            n_err++; $display("FAIL write_request: got %b %h want 11 08", reg_access, reg_addr);
        end
        n_cmp++;
        if (reg_wdata !== 32'h12345678 || reg_strb !== 4'b0101) begin
            n_err++; $display("FAIL write_wdata_strb: got %h %h want 12345678 5", reg_wdata, reg_strb);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_status !== RGGEN_OKAY || rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL write_rsp: got %b %0d %h want 1 0 0", rsp_valid, rsp_status, rsp_rdata);
        end
        step();
    endtask

    task automatic test_unmapped();
        reg_active  = 2'b00;
        reg_ready   = 2'b11;
        reg_rdata   = {32'h12121212, 32'h34343434};
        req_valid_b = 1'b1;
        issue(1'b0, 8'h40, 32'h0, 4'hF);
        req_valid_b = 1'b0;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_status !== RGGEN_DECODE_ERROR || rsp_rdata !== 32'hCAFE0000) begin
            n_err++;
            $display("FAIL unmapped_err: got %b %0d %h want 1 3 cafe0000", rsp_valid, rsp_status, rsp_rdata);
        end
        n_cmp++;
        if (b_rsp_valid !== 1'b1 || b_rsp_status !== RGGEN_OKAY || b_rsp_rdata !== 32'hCAFE0000) begin
            n_err++;
            $display("FAIL unmapped_okay: got %b %0d %h want 1 0 cafe0000",
                     b_rsp_valid, b_rsp_status, b_rsp_rdata);
        end
        step();
        n_cmp++;
        if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL unmapped_okay_idle: got %b %b want 1 0", b_req_ready, b_rsp_valid);
        end
    endtask

    task automatic test_timeout();
        reg_active = 2'b01;
        reg_ready  = 2'b00;
        reg_status = 4'b0000;
        reg_rdata  = {32'h0, 32'h77777777};
        issue(1'b0, 8'h00, 32'h0, 4'hF);
        for (int i = 1; i <= 4; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b0 || reg_valid !== 1'b1) begin
                n_err++;
                $display("FAIL timeout_wait_c%0d: got rspv %b regv %b want 0 1", i, rsp_valid, reg_valid);
            end
            step();
        end
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_status !== RGGEN_SLAVE_ERROR || rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL timeout_rsp: got %b %0d %h want 1 2 0", rsp_valid, rsp_status, rsp_rdata);
        end
        step();
        // Ready arrives in the third ACCESS cycle, before the timeout fires.
        issue(1'b0, 8'h00, 32'h0, 4'hF);
        for (int i = 1; i <= 2; i++) begin
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL late_ready_wait_c%0d: got %b want 0", i, rsp_valid);
            end
            step();
        end
        reg_ready = 2'b01;
        reg_rdata = {32'h0, 32'hA5A5A5A5};
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_status !== RGGEN_OKAY || rsp_rdata !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL late_ready_rsp: got %b %0d %h want 1 0 a5a5a5a5", rsp_valid, rsp_status, rsp_rdata);
        end
        step();
        reg_ready = 2'b00;
    endtask

    task automatic test_multi_stall();
        reg_active = 2'b11;
        reg_ready  = 2'b11;
        reg_status = 4'b0000;
        reg_rdata  = {32'h0F0F0F0F, 32'hF0F0F0F0};
        rsp_ready  = 1'b0;
        issue(1'b0, 8'h20, 32'h0, 4'hF);
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_status !== RGGEN_SLAVE_ERROR || rsp_rdata !== 32'h0) begin
            n_err++;
            $display("FAIL multi_rsp: got %b %0d %h want 1 2 0", rsp_valid, rsp_status, rsp_rdata);
        end
        // Register inputs change while the host stalls; the response must not.
        for (int i = 1; i <= 3; i++) begin
            reg_active = 2'b01;
            reg_rdata  = {32'h0, 32'h1234ABCD + i};
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_status !== RGGEN_SLAVE_ERROR || rsp_rdata !== 32'h0 ||
                req_ready !== 1'b0 || reg_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold_c%0d: got %b %0d %h reqr %b regv %b want 1 2 0 0 0",
                         i, rsp_valid, rsp_status, rsp_rdata, req_ready, reg_valid);
            end
        end
        rsp_ready = 1'b1;
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release: got %b %b want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_access();
        reg_active = 2'b01;
        reg_ready  = 2'b00;
        rsp_ready  = 1'b1;
        issue(1'b1, 8'h10, 32'h00000055, 4'hF);
        n_cmp++;
        if (reg_valid !== 1'b1 || reg_addr !== 8'h10) begin
            n_err++; $display("FAIL rst_acc_pre: got %b %h want 1 10", reg_valid, reg_addr);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (req_ready !== 1'b1 || reg_valid !== 1'b0 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_acc_state: got %b %b %b want 1 0 0", req_ready, reg_valid, rsp_valid);
        end
        n_cmp++;
        if (reg_addr !== 8'h00 || reg_wdata !== 32'h0 || reg_strb !== 4'h0 || reg_access !== 2'b00) begin
            n_err++;
            $display("FAIL rst_acc_outs: got %h %h %h %b want 00 0 0 00",
                     reg_addr, reg_wdata, reg_strb, reg_access);
        end
        n_cmp++;
        if (rsp_status !== 2'b00 || rsp_rdata !== 32'h0) begin
            n_err++; $display("FAIL rst_acc_rsp: got %0d %h want 0 0", rsp_status, rsp_rdata);
        end
        for (int i = 1; i <= 6; i++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_err++; $display("FAIL rst_acc_no_rsp_c%0d: got %b want 0", i, rsp_valid);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        req_strb    = '0;
        rsp_ready   = 1'b1;
        reg_active  = '0;
        reg_ready   = '0;
        reg_status  = '0;
        reg_rdata   = '0;
        test_reset();
        test_read();
        test_write();
        test_unmapped();
        test_timeout();
        test_multi_stall();
        test_reset_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
